// File: rtl/z16_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, decode handshake and redirect.
// The master modport is the fetch unit; the slave side is memory plus decode.
interface z16_fetch_unit_if;
  logic [15:0] o_imem_addr;
  logic [15:0] i_imem_instr;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_instr;
  logic [15:0] o_pc;
  logic [15:0] o_pc_next;
  logic        i_redirect;
  logic [15:0] i_redirect_addr;
  logic        o_fault;

  modport master (
    output o_imem_addr,
    input  i_imem_instr,
    output o_valid,
    input  i_ready,
    output o_instr,
    output o_pc,
    output o_pc_next,
    input  i_redirect,
    input  i_redirect_addr,
    output o_fault
  );

  modport slave (
    input  o_imem_addr,
    output i_imem_instr,
    input  o_valid,
    output i_ready,
    input  o_instr,
    input  o_pc,
    input  o_pc_next,
    output i_redirect,
    output i_redirect_addr,
    input  o_fault
  );
endinterface

// File: rtl/z16_fetch_unit.sv
// Z16 fetch: one-cycle latency, one instr/cycle; holds output while !i_ready, redirect flushes.
// Optional fetch bound check enabled by defining Z16_FETCH_BOUND_EN (default build: disabled).
module z16_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned MEM_WORDS = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  z16_fetch_unit_if.master  bus
);

`ifdef Z16_FETCH_BOUND_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [15:0] fetch_pc_q, fetch_pc_n;
  logic [15:0] instr_q, instr_n;
  logic [15:0] pc_q, pc_n;
  logic        valid_q, valid_n;
  logic        fault_q, fault_n;

  logic [31:0] word_idx;
  logic        bound_hit;
  logic        fetch_slot;

  assign word_idx   = {17'd0, fetch_pc_q[15:1]};
  assign bound_hit  = BOUND_EN && (word_idx >= MEM_WORDS);
  // The output slot is free when empty or being drained this cycle.
  assign fetch_slot = !valid_q || bus.i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_START;
      fetch_pc_q <= RESET_PC;
      instr_q    <= 16'h0000;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      instr_q    <= instr_n;
      pc_q       <= pc_n;
      valid_q    <= valid_n;
      fault_q    <= fault_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    fetch_pc_n = fetch_pc_q;
    instr_n    = instr_q;
    pc_n       = pc_q;
    valid_n    = valid_q;
    fault_n    = fault_q;

    if (bus.i_redirect) begin
      // Redirect wins everywhere; the held instruction is dropped.
      fetch_pc_n = bus.i_redirect_addr & 16'hFFFE;
      valid_n    = 1'b0;
      fault_n    = 1'b0;
      state_n    = S_RUN;
    end else begin
      case (state_q)
        S_START: begin
          state_n = S_RUN;
        end
        S_RUN: begin
          if (fetch_slot) begin
            if (bound_hit) begin
              valid_n = 1'b0;
              fault_n = 1'b1;
              state_n = S_FAULT;
            end else begin
              instr_n    = bus.i_imem_instr;
              pc_n       = fetch_pc_q;
              valid_n    = 1'b1;
              fetch_pc_n = fetch_pc_q + 16'd2;
            end
          end
        end
        S_FAULT: begin
          if (bus.i_ready) begin
            valid_n = 1'b0;
          end
        end
        default: begin
          state_n = S_START;
        end
      endcase
    end
  end

  assign bus.o_imem_addr = fetch_pc_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_instr     = instr_q;
  assign bus.o_pc        = pc_q;
  assign bus.o_pc_next   = pc_q + 16'd2;
  assign bus.o_fault     = fault_q;

endmodule
